// File: rtl/zap_wb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package zap_wb_arbiter_pkg;

  // Wishbone B3 cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_BURST   = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // One master's complete request bundle, as presented to the slave
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
  } wb_req_t;

  // Bus image driven while nobody owns it
  localparam wb_req_t WB_REQ_IDLE = '{
    cyc: 1'b0, stb: 1'b0, we: 1'b0,
    adr: 32'h0, dat: 32'h0, sel: 4'h0, cti: CTI_CLASSIC
  };

endpackage

// File: rtl/zap_wb_arbiter_watchdog.sv
// Bus-hang watchdog: saturating stall counter plus sticky timeout flag.
// TIMEOUT = 0 disables the flag entirely.
module zap_wb_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic timeout
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_ff;
  logic          timeout_ff;

  // Count stalled cycles, saturate at the limit; the flag sets on the
  // edge where the count reaches the limit and only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_ff   <= '0;
      timeout_ff <= 1'b0;
    end else begin
      if (clear) begin
        count_ff <= '0;
      end else if (stall && (count_ff != LIMIT)) begin
        count_ff <= count_ff + 1'b1;
      end
      if ((TIMEOUT != 0) && stall && !clear && (count_ff == LIMIT - 1'b1)) begin
        timeout_ff <= 1'b1;
      end
    end
  end

  assign timeout = timeout_ff;

endmodule

// File: rtl/zap_wb_arbiter.sv
// Two-master round-robin Wishbone B3 arbiter with whole-cycle grants.
// The owner keeps the bus until it drops CYC, so bursts are never split.
module zap_wb_arbiter
  import zap_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_wb_cyc,
  input  logic        i_m0_wb_stb,
  input  logic        i_m0_wb_we,
  input  logic [31:0] i_m0_wb_adr,
  input  logic [31:0] i_m0_wb_dat,
  input  logic [3:0]  i_m0_wb_sel,
  input  logic [2:0]  i_m0_wb_cti,
  output logic        o_m0_wb_ack,
  output logic [31:0] o_m0_wb_dat,
  input  logic        i_m1_wb_cyc,
  input  logic        i_m1_wb_stb,
  input  logic        i_m1_wb_we,
  input  logic [31:0] i_m1_wb_adr,
  input  logic [31:0] i_m1_wb_dat,
  input  logic [3:0]  i_m1_wb_sel,
  input  logic [2:0]  i_m1_wb_cti,
  output logic        o_m1_wb_ack,
  output logic [31:0] o_m1_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic [2:0]  o_wb_cti,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat,
  output logic        o_timeout
);

  arb_state_t state_ff, state_nxt;
  logic       pri_ff, pri_nxt;
  wb_req_t    bus;
  logic       wd_clear, wd_stall;

  // State and priority registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_ff <= ST_IDLE;
      pri_ff   <= 1'b0;
    end else begin
      state_ff <= state_nxt;
      pri_ff   <= pri_nxt;
    end
  end

  // Grant decision; releasing owner hands priority to the other master,
  // and every release passes through IDLE so owners never overlap.
  always_comb begin
    state_nxt = state_ff;
    pri_nxt   = pri_ff;
    case (state_ff)
      ST_IDLE: begin
        if (i_m0_wb_cyc && i_m1_wb_cyc) state_nxt = pri_ff ? ST_OWN1 : ST_OWN0;
        else if (i_m0_wb_cyc)           state_nxt = ST_OWN0;
        else if (i_m1_wb_cyc)           state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (!i_m0_wb_cyc) begin
          state_nxt = ST_IDLE;
          pri_nxt   = 1'b1;
        end
      end
      ST_OWN1: begin
        if (!i_m1_wb_cyc) begin
          state_nxt = ST_IDLE;
          pri_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus mux: owner's request goes straight through with no added delay
  always_comb begin
    bus = WB_REQ_IDLE;
    case (state_ff)
      ST_OWN0: bus = '{cyc: i_m0_wb_cyc, stb: i_m0_wb_stb, we: i_m0_wb_we,
                       adr: i_m0_wb_adr, dat: i_m0_wb_dat, sel: i_m0_wb_sel,
                       cti: i_m0_wb_cti};
      ST_OWN1: bus = '{cyc: i_m1_wb_cyc, stb: i_m1_wb_stb, we: i_m1_wb_we,
                       adr: i_m1_wb_adr, dat: i_m1_wb_dat, sel: i_m1_wb_sel,
                       cti: i_m1_wb_cti};
      default: bus = WB_REQ_IDLE;
    endcase
  end

  assign o_wb_cyc = bus.cyc;
  assign o_wb_stb = bus.stb;
  assign o_wb_we  = bus.we;
  assign o_wb_adr = bus.adr;
  assign o_wb_dat = bus.dat;
  assign o_wb_sel = bus.sel;
  assign o_wb_cti = bus.cti;

  // ACK only reaches the owner, and only while it is strobing
  assign o_m0_wb_ack = i_wb_ack && (state_ff == ST_OWN0) && i_m0_wb_stb;
  assign o_m1_wb_ack = i_wb_ack && (state_ff == ST_OWN1) && i_m1_wb_stb;
  assign o_m0_wb_dat = i_wb_dat;
  assign o_m1_wb_dat = i_wb_dat;

  assign wd_clear = (state_ff == ST_IDLE) || o_m0_wb_ack || o_m1_wb_ack;
  assign wd_stall = (state_ff != ST_IDLE) && bus.stb && !i_wb_ack;

  zap_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (i_clk),
    .reset   (i_reset),
    .clear   (wd_clear),
    .stall   (wd_stall),
    .timeout (o_timeout)
  );

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed self-checking bench for zap_wb_arbiter (TIMEOUT=8 and TIMEOUT=0).
module tb_zap_wb_arbiter;
  import zap_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [31:0] m0_adr = 0, m0_wdat = 0;
  logic [3:0] m0_sel = 0;
  logic [2:0] m0_cti = 0;
  logic m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = 0, m1_wdat = 0;
  logic [3:0] m1_sel = 0;
  logic [2:0] m1_cti = 0;
  logic s_ack = 0;
  logic [31:0] s_dat = 0;

  logic m0_ack, m1_ack, wb_cyc, wb_stb, wb_we, tmo;
  logic [31:0] m0_rdat, m1_rdat, wb_adr, wb_dat;
  logic [3:0] wb_sel;
  logic [2:0] wb_cti;

  logic off_m0_ack, off_m1_ack, off_cyc, off_stb, off_we, off_tmo;
  logic [31:0] off_m0_rdat, off_m1_rdat, off_adr, off_dat;
  logic [3:0] off_sel;
  logic [2:0] off_cti;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  zap_wb_arbiter #(.TIMEOUT(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .i_m0_wb_we(m0_we),
    .i_m0_wb_adr(m0_adr), .i_m0_wb_dat(m0_wdat), .i_m0_wb_sel(m0_sel), .i_m0_wb_cti(m0_cti),
    .o_m0_wb_ack(m0_ack), .o_m0_wb_dat(m0_rdat),
    .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .i_m1_wb_we(m1_we),
    .i_m1_wb_adr(m1_adr), .i_m1_wb_dat(m1_wdat), .i_m1_wb_sel(m1_sel), .i_m1_wb_cti(m1_cti),
    .o_m1_wb_ack(m1_ack), .o_m1_wb_dat(m1_rdat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
    .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_cti(wb_cti),
    .i_wb_ack(s_ack), .i_wb_dat(s_dat), .o_timeout(tmo)
  );

  zap_wb_arbiter #(.TIMEOUT(0)) dut_off (
    .i_clk(clk), .i_reset(rst),
    .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .i_m0_wb_we(m0_we),
    .i_m0_wb_adr(m0_adr), .i_m0_wb_dat(m0_wdat), .i_m0_wb_sel(m0_sel), .i_m0_wb_cti(m0_cti),
    .o_m0_wb_ack(off_m0_ack), .o_m0_wb_dat(off_m0_rdat),
    .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .i_m1_wb_we(m1_we),
    .i_m1_wb_adr(m1_adr), .i_m1_wb_dat(m1_wdat), .i_m1_wb_sel(m1_sel), .i_m1_wb_cti(m1_cti),
    .o_m1_wb_ack(off_m1_ack), .o_m1_wb_dat(off_m1_rdat),
    .o_wb_cyc(off_cyc), .o_wb_stb(off_stb), .o_wb_we(off_we), .o_wb_adr(off_adr),
    .o_wb_dat(off_dat), .o_wb_sel(off_sel), .o_wb_cti(off_cti),
    .i_wb_ack(s_ack), .i_wb_dat(s_dat), .o_timeout(off_tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_wdat = 0; m0_sel = 0; m0_cti = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_wdat = 0; m1_sel = 0; m1_cti = 0;
    s_ack = 0; s_dat = 0;
  endtask

  task automatic test_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA000_0000;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB000_0000;
    s_ack = 1;
    rst = 1'b1;
    step();
    step();
    total++; if (wb_cyc !== 1'b0) begin bad++; $display("FAIL reset_cyc got=%0h exp=0", wb_cyc); end
    total++; if (wb_adr !== 32'h0) begin bad++; $display("FAIL reset_adr got=%0h exp=0", wb_adr); end
    total++; if ({m0_ack, m1_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%0b exp=00", {m0_ack, m1_ack}); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0h exp=0", tmo); end
    rst = 1'b0;
    s_ack = 0;
    settle();
    total++; if (wb_cyc !== 1'b0) begin bad++; $display("FAIL reset_pregrant_cyc got=%0h exp=0", wb_cyc); end
    step();
    total++; if (wb_cyc !== 1'b1) begin bad++; $display("FAIL reset_grant_cyc got=%0h exp=1", wb_cyc); end
    total++; if (wb_adr !== 32'hA000_0000) begin bad++; $display("FAIL reset_grant_m0 got=%0h exp=a0000000", wb_adr); end
    idle_inputs();
    step();
  endtask

  task automatic test_contention();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100; m0_sel = 4'hF; m0_we = 1; m0_wdat = 32'h1111_2222;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0200; m1_sel = 4'h3;
    settle();
    total++; if (wb_cyc !== 1'b0) begin bad++; $display("FAIL cont_latency got=%0h exp=0", wb_cyc); end
    step();
    total++; if ({wb_cyc, wb_we, wb_adr, wb_dat, wb_sel} !== {1'b1, 1'b1, 32'h100, 32'h1111_2222, 4'hF})
      begin bad++; $display("FAIL cont_m0_bus got=%0h/%0h/%0h/%0h exp=1/100/11112222/f", wb_cyc, wb_adr, wb_dat, wb_sel); end
    s_ack = 1; s_dat = 32'hDEAD_BEEF;
    settle();
    total++; if ({m0_ack, m1_ack} !== 2'b10) begin bad++; $display("FAIL cont_ack_route got=%0b exp=10", {m0_ack, m1_ack}); end
    total++; if ({m0_rdat, m1_rdat} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF})
      begin bad++; $display("FAIL cont_rdat got=%0h/%0h exp=deadbeef", m0_rdat, m1_rdat); end
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    step();
    total++; if (wb_cyc !== 1'b0) begin bad++; $display("FAIL cont_idle_gap got=%0h exp=0", wb_cyc); end
    step();
    total++; if ({wb_cyc, wb_adr, wb_sel} !== {1'b1, 32'h200, 4'h3})
      begin bad++; $display("FAIL cont_m1_bus got=%0h/%0h/%0h exp=1/200/3", wb_cyc, wb_adr, wb_sel); end
    idle_inputs();
    step();
  endtask

  task automatic test_burst_lock();
    logic [2:0] ctis [4];
    ctis[0] = CTI_BURST; ctis[1] = CTI_BURST; ctis[2] = CTI_BURST; ctis[3] = CTI_EOB;
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h1000; m1_cti = ctis[0];
    step();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      m1_adr = 32'h1000 + 32'(4 * i); m1_cti = ctis[i]; s_ack = 1;
      settle();
      total++; if ({m1_ack, m0_ack} !== 2'b10) begin bad++; $display("FAIL burst_ack beat=%0d got=%0b exp=10", i, {m1_ack, m0_ack}); end
      total++; if ({wb_adr, wb_cti} !== {32'h1000 + 32'(4 * i), ctis[i]})
        begin bad++; $display("FAIL burst_bus beat=%0d got=%0h/%0b", i, wb_adr, wb_cti); end
      step();
    end
    m1_stb = 0; s_ack = 0;
    settle();
    total++; if ({wb_cyc, wb_adr} !== {1'b1, 32'h100C}) begin bad++; $display("FAIL burst_hold got=%0h/%0h exp=1/100c", wb_cyc, wb_adr); end
    step();
    m1_cyc = 0;
    step();
    total++; if ({wb_cyc, m0_ack} !== 2'b00) begin bad++; $display("FAIL burst_release got=%0b exp=00", {wb_cyc, m0_ack}); end
    step();
    total++; if ({wb_cyc, wb_adr} !== {1'b1, 32'h300}) begin bad++; $display("FAIL burst_m0_grant got=%0h/%0h exp=1/300", wb_cyc, wb_adr); end
    idle_inputs();
    step();
  endtask

  task automatic test_fairness();
    logic [31:0] exp_adr [4];
    exp_adr[0] = 32'hA0; exp_adr[1] = 32'hB0; exp_adr[2] = 32'hA0; exp_adr[3] = 32'hB0;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB0;
    for (int t = 0; t < 4; t++) begin
      step();
      total++; if ({wb_cyc, wb_adr} !== {1'b1, exp_adr[t]})
        begin bad++; $display("FAIL fair_owner txn=%0d got=%0h exp=%0h", t, wb_adr, exp_adr[t]); end
      s_ack = 1;
      step();
      s_ack = 0;
      if (exp_adr[t] == 32'hA0) begin m0_cyc = 0; m0_stb = 0; end
      else begin m1_cyc = 0; m1_stb = 0; end
      step();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_watchdog_clear();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
    step();
    for (int i = 0; i < 5; i++) step();
    s_ack = 1;
    step();
    s_ack = 0;
    for (int i = 0; i < 5; i++) step();
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL wd_ack_clears got=%0h exp=0", tmo); end
    idle_inputs();
    step();
  endtask

  task automatic test_watchdog();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h50;
    step();
    for (int i = 1; i <= 8; i++) begin
      step();
      total++; if (tmo !== (i >= 8)) begin bad++; $display("FAIL wd_stall n=%0d got=%0h exp=%0h", i, tmo, (i >= 8)); end
    end
    for (int i = 0; i < 4; i++) step();
    s_ack = 1;
    step();
    step();
    s_ack = 0;
    step();
    total++; if (tmo !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%0h exp=1", tmo); end
    total++; if (off_tmo !== 1'b0) begin bad++; $display("FAIL wd_disabled got=%0h exp=0", off_tmo); end
    m0_cyc = 0; m0_stb = 0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h2000; m0_cti = CTI_BURST;
    step();
    s_ack = 1;
    step();
    m0_adr = 32'h2004;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000;
    settle();
    total++; if ({wb_cyc, wb_stb, wb_adr} !== {1'b0, 1'b0, 32'h0})
      begin bad++; $display("FAIL rmb_idle got=%0h/%0h/%0h exp=0/0/0", wb_cyc, wb_stb, wb_adr); end
    total++; if ({m0_ack, m1_ack} !== 2'b00) begin bad++; $display("FAIL rmb_stray_ack got=%0b exp=00", {m0_ack, m1_ack}); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rmb_timeout got=%0h exp=0", tmo); end
    s_ack = 0;
    step();
    total++; if ({wb_cyc, wb_adr} !== {1'b1, 32'h2004})
      begin bad++; $display("FAIL rmb_pri got=%0h/%0h exp=1/2004", wb_cyc, wb_adr); end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_contention();
    test_burst_lock();
    test_fairness();
    test_watchdog_clear();
    test_watchdog();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
